// File: rtl/vga_timing_pkg.sv
// Shared VGA raster defaults and helpers for the frame-buffer display and capture paths.
package vga_timing_pkg;

   localparam int unsigned H_ACTIVE_DEF = 640;
   localparam int unsigned H_FP_DEF     = 16;
   localparam int unsigned H_SYNC_DEF   = 96;
   localparam int unsigned H_BP_DEF     = 48;
   localparam int unsigned V_ACTIVE_DEF = 480;
   localparam int unsigned V_FP_DEF     = 10;
   localparam int unsigned V_SYNC_DEF   = 2;
   localparam int unsigned V_BP_DEF     = 33;

   localparam int unsigned H_TOTAL = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
   localparam int unsigned V_TOTAL = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

   localparam int unsigned PIXEL_BITS = 8;
   typedef logic [PIXEL_BITS-1:0] pixel_t;

   // Bits needed to hold the values 0..n-1 (at least one bit).
   function automatic int unsigned cnt_width(input int unsigned n);
      int unsigned w;
      w = 1;
      while ((32'd1 << w) < n) w = w + 1;
      return w;
   endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster counters with sync and visible-area decode.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
   parameter int unsigned H_FP     = H_FP_DEF,
   parameter int unsigned H_SYNC   = H_SYNC_DEF,
   parameter int unsigned H_BP     = H_BP_DEF,
   parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
   parameter int unsigned V_FP     = V_FP_DEF,
   parameter int unsigned V_SYNC   = V_SYNC_DEF,
   parameter int unsigned V_BP     = V_BP_DEF,
   parameter int unsigned HW       = cnt_width(H_ACTIVE + H_FP + H_SYNC + H_BP),
   parameter int unsigned VW       = cnt_width(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
   input  logic          clk_i,
   input  logic          rst_n,
   output logic [HW-1:0] h_cnt_o,
   output logic [VW-1:0] v_cnt_o,
   output logic          hsync_o,
   output logic          vsync_o,
   output logic          visible_o,
   output logic          line_end_o,
   output logic          frame_end_o
);

   localparam logic [HW-1:0] HLast    = HW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [HW-1:0] HAct     = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HSyncBeg = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HSyncEnd = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] VLast    = VW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [VW-1:0] VAct     = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VSyncBeg = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VSyncEnd = VW'(V_ACTIVE + V_FP + V_SYNC);

   logic [HW-1:0] h_q, h_d;
   logic [VW-1:0] v_q, v_d;
   logic          line_end, frame_end;

   assign line_end  = (h_q == HLast);
   assign frame_end = line_end && (v_q == VLast);

   always_comb begin
      h_d = h_q + HW'(1);
      v_d = v_q;
      if (line_end) begin
         h_d = '0;
         v_d = frame_end ? '0 : v_q + VW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         h_q <= '0;
         v_q <= '0;
      end else begin
         h_q <= h_d;
         v_q <= v_d;
      end
   end

   assign h_cnt_o     = h_q;
   assign v_cnt_o     = v_q;
   assign hsync_o     = !((h_q >= HSyncBeg) && (h_q < HSyncEnd));
   assign vsync_o     = !((v_q >= VSyncBeg) && (v_q < VSyncEnd));
   assign visible_o   = (h_q < HAct) && (v_q < VAct);
   assign line_end_o  = line_end;
   assign frame_end_o = frame_end;

endmodule

// File: rtl/vga_frame_reader.sv
// Reads the camera frame RAM in raster order, upscaling by SCALE, and drives VGA outputs
// through a two-stage pipeline that keeps sync, enable and pixel data aligned.
module vga_frame_reader
   import vga_timing_pkg::*;
#(
   parameter int unsigned H_ACTIVE  = H_ACTIVE_DEF,
   parameter int unsigned H_FP      = H_FP_DEF,
   parameter int unsigned H_SYNC    = H_SYNC_DEF,
   parameter int unsigned H_BP      = H_BP_DEF,
   parameter int unsigned V_ACTIVE  = V_ACTIVE_DEF,
   parameter int unsigned V_FP      = V_FP_DEF,
   parameter int unsigned V_SYNC    = V_SYNC_DEF,
   parameter int unsigned V_BP      = V_BP_DEF,
   parameter int unsigned HSIZE     = 160,
   parameter int unsigned VSIZE     = 120,
   parameter int unsigned SCALE     = 4,
   parameter int unsigned ADDR_BITS = 15,
   parameter int unsigned DATA_BITS = PIXEL_BITS,
   parameter logic [DATA_BITS-1:0] BORDER = '0
) (
   input  logic                 pclk_i,
   input  logic                 rst_n,
   output logic                 rd_en_o,
   output logic [ADDR_BITS-1:0] rd_addr_o,
   input  logic [DATA_BITS-1:0] rd_data_i,
   output logic                 hsync_o,
   output logic                 vsync_o,
   output logic                 de_o,
   output logic [DATA_BITS-1:0] pixel_o,
   output logic                 frame_start_o
);

   localparam int unsigned HW = cnt_width(H_ACTIVE + H_FP + H_SYNC + H_BP);
   localparam int unsigned VW = cnt_width(V_ACTIVE + V_FP + V_SYNC + V_BP);
   localparam int unsigned SW = cnt_width(SCALE);

   localparam logic [HW-1:0]        ImgW     = HW'(HSIZE * SCALE);
   localparam logic [VW-1:0]        ImgH     = VW'(VSIZE * SCALE);
   localparam logic [VW-1:0]        ImgHLast = VW'(VSIZE * SCALE - 1);
   localparam logic [SW-1:0]        SubLast  = SW'(SCALE - 1);
   localparam logic [ADDR_BITS-1:0] LineStep = ADDR_BITS'(HSIZE);

   logic [HW-1:0] h_cnt;
   logic [VW-1:0] v_cnt;
   logic          hsync, vsync, visible, line_end, frame_end, img;

   vga_timing_gen #(
      .H_ACTIVE (H_ACTIVE),
      .H_FP     (H_FP),
      .H_SYNC   (H_SYNC),
      .H_BP     (H_BP),
      .V_ACTIVE (V_ACTIVE),
      .V_FP     (V_FP),
      .V_SYNC   (V_SYNC),
      .V_BP     (V_BP),
      .HW       (HW),
      .VW       (VW)
   ) u_timing (
      .clk_i       (pclk_i),
      .rst_n       (rst_n),
      .h_cnt_o     (h_cnt),
      .v_cnt_o     (v_cnt),
      .hsync_o     (hsync),
      .vsync_o     (vsync),
      .visible_o   (visible),
      .line_end_o  (line_end),
      .frame_end_o (frame_end)
   );

   assign img = (h_cnt < ImgW) && (v_cnt < ImgH) && visible;

   logic [SW-1:0]        x_sub_q, x_sub_d, y_sub_q, y_sub_d;
   logic [ADDR_BITS-1:0] col_q, col_d, base_q, base_d, hold_q;

   // Incremental address walk; line_base only advances between stored lines.
   always_comb begin
      x_sub_d = x_sub_q;
      col_d   = col_q;
      y_sub_d = y_sub_q;
      base_d  = base_q;
      if (line_end) begin
         x_sub_d = '0;
         col_d   = '0;
         if (frame_end) begin
            y_sub_d = '0;
            base_d  = '0;
         end else if (v_cnt < ImgH) begin
            if (y_sub_q == SubLast) begin
               y_sub_d = '0;
               if (v_cnt != ImgHLast) base_d = base_q + LineStep;
            end else begin
               y_sub_d = y_sub_q + SW'(1);
            end
         end
      end else if (img) begin
         if (x_sub_q == SubLast) begin
            x_sub_d = '0;
            col_d   = col_q + ADDR_BITS'(1);
         end else begin
            x_sub_d = x_sub_q + SW'(1);
         end
      end
   end

   // Counters sit at (0,0) during reset, so the read strobe is held off by rst_n itself.
   assign rd_en_o   = img & rst_n;
   assign rd_addr_o = img ? (base_q + col_q) : hold_q;

   logic                 s1_img_q, s1_vis_q, s1_hs_q, s1_vs_q, s1_fs_q;
   logic                 de_q, hs_q, vs_q, fs_q;
   logic [DATA_BITS-1:0] pix_q, pix_d;

   always_comb begin
      pix_d = '0;
      if (s1_img_q)      pix_d = rd_data_i;
      else if (s1_vis_q) pix_d = BORDER;
   end

   always_ff @(posedge pclk_i or negedge rst_n) begin
      if (!rst_n) begin
         x_sub_q  <= '0;
         y_sub_q  <= '0;
         col_q    <= '0;
         base_q   <= '0;
         hold_q   <= '0;
         s1_img_q <= 1'b0;
         s1_vis_q <= 1'b0;
         s1_hs_q  <= 1'b1;
         s1_vs_q  <= 1'b1;
         s1_fs_q  <= 1'b0;
         pix_q    <= '0;
         de_q     <= 1'b0;
         hs_q     <= 1'b1;
         vs_q     <= 1'b1;
         fs_q     <= 1'b0;
      end else begin
         x_sub_q  <= x_sub_d;
         y_sub_q  <= y_sub_d;
         col_q    <= col_d;
         base_q   <= base_d;
         hold_q   <= rd_addr_o;
         s1_img_q <= img;
         s1_vis_q <= visible;
         s1_hs_q  <= hsync;
         s1_vs_q  <= vsync;
         s1_fs_q  <= (h_cnt == '0) && (v_cnt == '0);
         pix_q    <= pix_d;
         de_q     <= s1_vis_q;
         hs_q     <= s1_hs_q;
         vs_q     <= s1_vs_q;
         fs_q     <= s1_fs_q;
      end
   end

   assign pixel_o       = pix_q;
   assign de_o          = de_q;
   assign hsync_o       = hs_q;
   assign vsync_o       = vs_q;
   assign frame_start_o = fs_q;

endmodule
